// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and the NOP / PC step values used by fetch and IF/ID.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [15:0] INST_NOP = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'd2;

endpackage

// File: rtl/IF_ID_Reg.sv
// IF/ID pipeline register: loads on enable, flush inserts a NOP bubble and keeps PC fields.
// Latency 1 cycle; flush overrides enable, and with neither asserted the contents hold.
module IF_ID_Reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_flush,
  input  logic [15:0] i_inst,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_pcplus2,
  output logic [15:0] o_inst,
  output logic [15:0] o_pc,
  output logic [15:0] o_pcplus2,
  output logic        o_vld
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_inst    <= INST_NOP;
      o_pc      <= 16'h0000;
      o_pcplus2 <= 16'h0000;
      o_vld     <= 1'b0;
    end else if (i_flush) begin
      o_inst <= INST_NOP;
      o_vld  <= 1'b0;
    end else if (i_en) begin
      o_inst    <= i_inst;
      o_pc      <= i_pc;
      o_pcplus2 <= i_pcplus2;
      o_vld     <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, variable-latency imem handshake, one-entry hold buffer and redirect drop.
// One instruction per cycle with zero-latency memory; stallD parks a returned word in HOLD.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [15:0] PCTargetE,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemRdata,
  input  logic        imemReady,
  output logic [15:0] inst,
  output logic [15:0] PCPlus2,
  output logic [15:0] PCD,
  output logic        instValidD
);

  fetch_state_t r_state;
  logic [15:0]  r_pcf;
  logic [15:0]  r_tgt;
  logic [15:0]  r_hold_inst;
  logic [15:0]  r_hold_pc;
  logic         r_imem_req;

  fetch_state_t w_state_nxt;
  logic [15:0]  w_pcf_nxt;
  logic [15:0]  w_tgt_nxt;
  logic [15:0]  w_pcf_inc;
  logic         w_hold_ld;
  logic         w_ifid_en;
  logic [15:0]  w_ifid_inst;
  logic [15:0]  w_ifid_pc;
  logic [15:0]  w_ifid_pcplus2;

  assign w_pcf_inc      = r_pcf + PC_STEP;
  assign w_ifid_pcplus2 = w_ifid_pc + PC_STEP;
  assign imemReq        = r_imem_req;
  assign imemAddr       = r_pcf;

  always_comb begin
    w_state_nxt = r_state;
    w_pcf_nxt   = r_pcf;
    w_tgt_nxt   = r_tgt;
    w_hold_ld   = 1'b0;
    w_ifid_en   = 1'b0;
    w_ifid_inst = imemRdata;
    w_ifid_pc   = r_pcf;
    case (r_state)
      IDLE: begin
        // imemReady is ignored here: any request before reset was abandoned
        w_state_nxt = REQ;
        if (PCSrcE) w_pcf_nxt = PCTargetE;
      end
      REQ: begin
        if (imemReady) begin
          if (PCSrcE) begin
            w_pcf_nxt = PCTargetE;
          end else begin
            w_pcf_nxt = w_pcf_inc;
            if (stallD) begin
              w_hold_ld   = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_ifid_en = 1'b1;
            end
          end
        end else if (PCSrcE) begin
          w_tgt_nxt   = PCTargetE;
          w_state_nxt = DROP;
        end
      end
      HOLD: begin
        w_ifid_inst = r_hold_inst;
        w_ifid_pc   = r_hold_pc;
        if (PCSrcE) begin
          w_pcf_nxt   = PCTargetE;
          w_state_nxt = REQ;
        end else if (!stallD) begin
          w_ifid_en   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      DROP: begin
        // the address stays on the bus until the stale word returns
        if (imemReady) begin
          w_pcf_nxt   = PCSrcE ? PCTargetE : r_tgt;
          w_state_nxt = REQ;
        end else if (PCSrcE) begin
          w_tgt_nxt = PCTargetE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pcf       <= RESET_PC;
      r_tgt       <= 16'h0000;
      r_hold_inst <= INST_NOP;
      r_hold_pc   <= 16'h0000;
      r_imem_req  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_tgt      <= w_tgt_nxt;
      r_imem_req <= (w_state_nxt == REQ) || (w_state_nxt == DROP);
      if (w_hold_ld) begin
        r_hold_inst <= imemRdata;
        r_hold_pc   <= r_pcf;
      end
    end
  end

  IF_ID_Reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_ifid_en),
    .i_flush   (flushD),
    .i_inst    (w_ifid_inst),
    .i_pc      (w_ifid_pc),
    .i_pcplus2 (w_ifid_pcplus2),
    .o_inst    (inst),
    .o_pc      (PCD),
    .o_pcplus2 (PCPlus2),
    .o_vld     (instValidD)
  );

endmodule
